// File: rtl/vend_key_filter_if.sv
// Key-filter bus: raw active-low key lines in, clean one-cycle pulses out.
// coin_cnt exists only when VEND_COIN_CNT_EN is defined.
interface vend_key_filter_if;
  logic       key_coin_n;
  logic       key_refund_n;
  logic       coin;
  logic       refund_request;
`ifdef VEND_COIN_CNT_EN
  logic [7:0] coin_cnt;
`endif

  modport master (
    output key_coin_n,
    output key_refund_n,
    input  coin,
`ifdef VEND_COIN_CNT_EN
    input  coin_cnt,
`endif
    input  refund_request
  );

  modport slave (
    input  key_coin_n,
    input  key_refund_n,
    output coin,
`ifdef VEND_COIN_CNT_EN
    output coin_cnt,
`endif
    output refund_request
  );
endinterface

// File: rtl/vend_key_filter.sv
// Synchronise and debounce the coin/refund keys into single-cycle pulses.
// Optional VEND_COIN_CNT_EN adds an 8-bit wrapping accepted-coin counter.
module vend_key_filter #(
  parameter int unsigned CNT_MAX = 999_999,
  parameter int unsigned CNT_W   = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  vend_key_filter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRESS_FLT, DOWN, REL_FLT} state_t;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  // bit 0 = coin, bit 1 = refund
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] acc;
  logic       coin_q;
  logic       refund_q;
  logic       refund_pend;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= {bus.key_refund_n, bus.key_coin_n};
      s2 <= s1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_key
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc_k;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_k   = 1'b0;
      case (state_q)
        IDLE: begin
          if (!s2[k]) begin
            state_d = PRESS_FLT;
            cnt_d   = '0;
          end
        end
        PRESS_FLT: begin
          if (s2[k]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TOP) begin
            state_d = DOWN;
            cnt_d   = '0;
            acc_k   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DOWN: begin
          if (s2[k]) begin
            state_d = REL_FLT;
            cnt_d   = '0;
          end
        end
        REL_FLT: begin
          if (!s2[k]) begin
            state_d = DOWN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TOP) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign acc = {g_key[1].acc_k, g_key[0].acc_k};

  // Coin wins a simultaneous accept; the refund is deferred one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      coin_q      <= 1'b0;
      refund_q    <= 1'b0;
      refund_pend <= 1'b0;
    end else begin
      coin_q      <= acc[0];
      refund_q    <= (acc[1] & ~acc[0]) | refund_pend;
      refund_pend <= acc[1] & acc[0];
    end
  end

  assign bus.coin           = coin_q;
  assign bus.refund_request = refund_q;

`ifdef VEND_COIN_CNT_EN
  logic [7:0] coin_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      coin_cnt_q <= '0;
    end else if (acc[0]) begin
      coin_cnt_q <= coin_cnt_q + 8'd1;
    end
  end

  assign bus.coin_cnt = coin_cnt_q;
`endif

endmodule

// File: doc/vend_key_filter.md
Name: vend_key_filter

Overview:
Input conditioning stage that sits directly upstream of the vending-machine FSM. It takes two raw, bouncy, active-low push-button/sensor lines (coin slot, refund button) and synchronises and debounces them. It emits clean single-cycle `coin` and `refund_request` pulses that the FSM consumes. Each accepted press yields exactly one pulse, regardless of hold time or contact bounce.

Parameters:
CNT_MAX, 999_999, debounce terminal count; a level must be stable for CNT_MAX+1 consecutive clocks to be accepted (20 ms at 50 MHz). Legal range 1..2^20-1.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > CNT_MAX.

Ports:
sys_clk  input  1  system clock; one clock domain.
sys_rst  input  1  synchronous reset, active-high.
key_coin_n  input  1  raw coin sensor, active-low, asynchronous, may bounce.
key_refund_n  input  1  raw refund button, active-low, asynchronous, may bounce.
coin  output  1  one-cycle pulse per accepted coin press.
refund_request  output  1  one-cycle pulse per accepted refund press.
coin_cnt  output  8  accepted-coin count; present only with VEND_COIN_CNT_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All flops update on the rising edge of sys_clk. sys_rst is sampled only on that edge.
- Reset values:
  - coin=0, refund_request=0, coin_cnt=0.
  - Synchroniser flops=1 (released).
  - Per-key FSMs=IDLE, counters=0, refund_pend=0.
- Synchroniser: two-flop per key (s1, s2). The FSMs see only s2.
- Per-key FSM, two independent instances, states IDLE, PRESS_FLT, DOWN, REL_FLT:
  - IDLE: if s2==0, go to PRESS_FLT with cnt=0. Otherwise stay.
  - PRESS_FLT:
    - s2==1: go to IDLE, cnt=0 (bounce rejected, no pulse).
    - s2==0 and cnt==CNT_MAX: go to DOWN and assert the accept strobe for one cycle.
    - Otherwise: cnt++.
  - DOWN: if s2==1, go to REL_FLT with cnt=0. Otherwise stay (holding never re-pulses).
  - REL_FLT:
    - s2==0: go to DOWN, cnt=0.
    - s2==1 and cnt==CNT_MAX: go to IDLE, cnt=0.
    - Otherwise: cnt++.
- Latency:
  - Raw line first sampled low at edge 0 and held low: pulse is visible in the cycle following edge CNT_MAX+3.
  - Release needs CNT_MAX+1 stable-high samples before a new press can be filtered.
- Outputs are registered; each pulse is exactly 1 cycle wide.
- Simultaneous accept (both strobes in the same cycle):
  - coin is pulsed that cycle; refund_pend is set.
  - refund_request is pulsed the next cycle and refund_pend is cleared.
  - This preserves coin priority, matching the downstream FSM.
  - Because CNT_MAX≥1, no second accept can overlap a pending refund.
- Reset mid-operation: any state or counter returns to its reset value on the next edge. A pending refund is discarded. No pulse is emitted in the cycle after reset.
- Counter never wraps in the filter states; it is bounded by CNT_MAX.

Optional Feature:
Macro VEND_COIN_CNT_EN.
- Defined: the 8-bit coin_cnt port exists.
  - It increments by 1 in the same cycle coin is asserted, wrapping 255→0.
  - It is cleared by sys_rst.
  - Intended for service/diagnostic display.
- Undefined: coin_cnt port and logic are absent. Module behaviour is otherwise identical.

Test Plan:
- Clean coin press, CNT_MAX=4: key_coin_n low at edge 0, held 20 clocks, then high → coin=1 for exactly 1 cycle after edge 7; no second pulse; refund_request stays 0.
- Bounce rejection, CNT_MAX=4: key_coin_n pattern low 3 clocks / high 1 / low 3 / high, repeated 5 times → no pulse. Then hold low 10 clocks → exactly one coin pulse, 7 clocks after the last low edge.
- Release bounce: press accepted, then release with 2-clock high glitches shorter than CNT_MAX+1 → no extra pulse. Next clean press after a full stable release → second pulse.
- Simultaneous press: both keys driven low on the same edge, CNT_MAX=4 → coin after edge 7, refund_request after edge 8, each 1 cycle.
- Reset mid-filter: key_coin_n low, sys_rst=1 at edge 4 for 1 cycle, key still low → outputs 0 during reset. Pulse appears only after a fresh CNT_MAX+3 window counted from reset release.
- VEND_COIN_CNT_EN: 257 accepted coin presses → coin_cnt reads 1; a refund press leaves coin_cnt unchanged.
